gpio_in: RTL and testbench

Memory-mapped 8-bit general-purpose input port on the CPU data bus. It is the read-side counterpart of the GPIO output register in the FPGA top. It synchronizes and debounces external pins, latches rising and falling edges into sticky write-1-to-clear status registers, and raises a level interrupt. The CPU reads pin state and status through `data_rd` with the same one-cycle read latency as `ram`.

---
 rtl/gpio_in_pkg.sv | 16 +
 rtl/gpio_in_debounce.sv | 67 ++++++
 rtl/gpio_in.sv | 94 +++++++++
 tb/tb_gpio_in.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/gpio_in_pkg.sv
// Shared definitions for the memory-mapped GPIO input port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpio_in_pkg;

    localparam int GPIO_IN_WIDTH = 8;

    // Word index within the block, taken from data_addr[3:2].
    typedef enum logic [1:0] {
        GPIO_IN_DATA = 2'd0,
        GPIO_IN_RISE = 2'd1,
        GPIO_IN_FALL = 2'd2,
        GPIO_IN_IEN  = 2'd3
    } gpio_in_reg_e;

endpackage

// File: rtl/gpio_in_debounce.sv
// One-bit synchronizer plus debouncer with single-cycle rise/fall pulses.
// Latency: 2 sync edges + DEBOUNCE stable edges from pin change to level_o.
// Backpressure: none; pulses are one cycle wide and must be consumed at once.
module gpio_in_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);

    logic          meta_q;
    logic          s_q;
    logic          d_q;
    logic          d_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
        end else begin
            meta_q <= pin_i;
            s_q    <= meta_q;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_comb begin
        accept = (s_q != d_q) && (cnt_q == CNT_MAX);
        d_d    = d_q;
        cnt_d  = '0;
        if (s_q != d_q) begin
            if (cnt_q == CNT_MAX) begin
                d_d = s_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Debounced level and counter state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end

    // Pulses are combinational so the sticky flag lands on the same edge as d.
    assign level_o = d_q;
    assign rise_o  = accept & s_q;
    assign fall_o  = accept & ~s_q;

endmodule

// File: rtl/gpio_in.sv
// 8-bit GPIO input port: debounced pins, sticky W1C edge flags, level IRQ.
// Latency: 1-cycle registered read; irq_o combinational from flag/enable regs.
// Backpressure: none; every bus access completes in one cycle.
module gpio_in
    import gpio_in_pkg::*;
#(
    parameter int BASE_PAGE = 2,
    parameter int DEBOUNCE  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [GPIO_IN_WIDTH-1:0] gpio_i,
    input  logic [31:0]              data_addr,
    input  logic [3:0]               datamem_wr,
    input  logic [7:0]               data_wr0,
    output logic [31:0]              data_rd,
    output logic                     irq_o
);

    localparam logic [21:0] PAGE = 22'(BASE_PAGE);

    logic [GPIO_IN_WIDTH-1:0] level;
    logic [GPIO_IN_WIDTH-1:0] rise_p;
    logic [GPIO_IN_WIDTH-1:0] fall_p;

    logic [GPIO_IN_WIDTH-1:0] rise_q, rise_d;
    logic [GPIO_IN_WIDTH-1:0] fall_q, fall_d;
    logic [GPIO_IN_WIDTH-1:0] ien_q,  ien_d;
    logic [31:0]              rd_q,   rd_d;

    logic                     sel;
    logic                     wr_en;
    gpio_in_reg_e             idx;
    logic                     unused_bits;

    genvar g;
    generate
        for (g = 0; g < GPIO_IN_WIDTH; g++) begin : g_pin
            gpio_in_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_db (
                .clk     (clk),
                .rstn    (rstn),
                .pin_i   (gpio_i[g]),
                .level_o (level[g]),
                .rise_o  (rise_p[g]),
                .fall_o  (fall_p[g])
            );
        end
    endgenerate

    // Address bits [9:4] alias the register set; upper strobes are not decoded.
    assign unused_bits = ^{datamem_wr[3:1], data_addr[9:4], data_addr[1:0]};

    assign sel   = (data_addr[31:10] == PAGE);
    assign wr_en = sel & datamem_wr[0];
    assign idx   = gpio_in_reg_e'(data_addr[3:2]);

    // Register next-state: W1C clears applied first so a same-cycle set wins.
    always_comb begin
        rise_d = (rise_q & ~((wr_en && idx == GPIO_IN_RISE) ? data_wr0 : 8'h00)) | rise_p;
        fall_d = (fall_q & ~((wr_en && idx == GPIO_IN_FALL) ? data_wr0 : 8'h00)) | fall_p;
        ien_d  = (wr_en && idx == GPIO_IN_IEN) ? data_wr0 : ien_q;
        rd_d   = 32'h0;
        if (sel) begin
            unique case (idx)
                GPIO_IN_DATA: rd_d = {24'h0, level};
                GPIO_IN_RISE: rd_d = {24'h0, rise_q};
                GPIO_IN_FALL: rd_d = {24'h0, fall_q};
                GPIO_IN_IEN:  rd_d = {24'h0, ien_q};
                default:      rd_d = 32'h0;
            endcase
        end
    end

    // Sticky flags, enables and the registered read port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rise_q <= '0;
            fall_q <= '0;
            ien_q  <= '0;
            rd_q   <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            ien_q  <= ien_d;
            rd_q   <= rd_d;
        end
    end

    assign data_rd = rd_q;
    assign irq_o   = |((rise_q | fall_q) & ien_q);

endmodule

// File: tb/tb_gpio_in.sv
// Directed bench for gpio_in with DEBOUNCE=4, BASE_PAGE=2.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_gpio_in;

    logic        clk;
    logic        rstn;
    logic [7:0]  gpio_i;
    logic [31:0] data_addr;
    logic [3:0]  datamem_wr;
    logic [7:0]  data_wr0;
    logic [31:0] data_rd;
    logic        irq_o;

    int n_chk = 0;
    int n_err = 0;

    gpio_in #(
        .BASE_PAGE (2),
        .DEBOUNCE  (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .gpio_i     (gpio_i),
        .data_addr  (data_addr),
        .datamem_wr (datamem_wr),
        .data_wr0   (data_wr0),
        .data_rd    (data_rd),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus cycle, then the bus returns to idle (sel low).
    task automatic bus(input logic [31:0] a, input logic [3:0] we, input logic [7:0] wd);
        data_addr  = a;
        datamem_wr = we;
        data_wr0   = wd;
        tick(1);
        data_addr  = 32'h0;
        datamem_wr = 4'h0;
        data_wr0   = 8'h0;
    endtask

    task automatic rd(input int idx, input logic [31:0] exp, input string tag);
        bus(32'h800 + 32'(idx * 4), 4'h0, 8'h00);
        chk(tag, data_rd, exp);
    endtask

    task automatic wr(input int idx, input logic [7:0] val);
        bus(32'h800 + 32'(idx * 4), 4'h1, val);
    endtask

    initial begin
        rstn       = 1'b0;
        gpio_i     = 8'h00;
        data_addr  = 32'h0;
        datamem_wr = 4'h0;
        data_wr0   = 8'h00;

        // Reset state
        tick(3);
        rstn = 1'b1;
        rd(0, 32'h0, "rst_data");
        rd(1, 32'h0, "rst_rise");
        rd(2, 32'h0, "rst_fall");
        rd(3, 32'h0, "rst_ien");
        chk("rst_irq", {31'h0, irq_o}, 32'h0);

        // Rising edge on pin 3: d and RISE update at the 6th edge
        gpio_i[3] = 1'b1;
        tick(5);
        rd(0, 32'h00, "rise_data_edge6_pre");
        rd(0, 32'h08, "rise_data");
        rd(1, 32'h08, "rise_flag");
        wr(3, 8'h08);
        chk("rise_irq_on", {31'h0, irq_o}, 32'h1);
        wr(1, 8'h08);
        chk("rise_irq_off", {31'h0, irq_o}, 32'h0);
        rd(1, 32'h00, "rise_cleared");

        // Glitch of 3 cycles on pin 0 is rejected
        gpio_i[0] = 1'b1;
        tick(3);
        gpio_i[0] = 1'b0;
        tick(6);
        rd(0, 32'h08, "glitch_data");
        rd(1, 32'h00, "glitch_rise");
        rd(2, 32'h00, "glitch_fall");
        gpio_i[0] = 1'b1;
        tick(8);
        rd(0, 32'h09, "hold_data");
        rd(1, 32'h01, "hold_rise");
        wr(1, 8'h00);
        rd(1, 32'h01, "w1c_zero_keeps");

        // Falling edge on pin 5 with a clear landing on the flag-set edge
        gpio_i[5] = 1'b1;
        tick(8);
        wr(1, 8'hFF);
        rd(1, 32'h00, "rise_clear_all");
        gpio_i[5] = 1'b0;
        tick(5);
        wr(2, 8'h20);
        rd(2, 32'h20, "collide_set_wins");
        rd(0, 32'h09, "fall_data");
        wr(3, 8'h20);
        chk("fall_irq_on", {31'h0, irq_o}, 32'h1);
        wr(3, 8'h00);
        chk("ien_mask_irq", {31'h0, irq_o}, 32'h0);
        rd(2, 32'h20, "mask_keeps_flag");
        wr(2, 8'h20);
        rd(2, 32'h00, "fall_cleared");

        // Decode
        bus(32'h0000_040C, 4'h1, 8'hFF);
        rd(3, 32'h00, "wrong_page_wr");
        bus(32'h0000_0400, 4'h0, 8'h00);
        chk("nosel_rd", data_rd, 32'h0);
        bus(32'h0000_080C, 4'b1110, 8'hFF);
        rd(3, 32'h00, "upper_strobe_wr");
        bus(32'h0000_0830, 4'h0, 8'h00);
        chk("alias_rd", data_rd, 32'h09);

        // Reset in the middle of counting
        wr(3, 8'hFF);
        gpio_i = 8'hFF;
        tick(3);
        rd(3, 32'hFF, "pre_rst_ien");
        rstn = 1'b0;
        #1;
        chk("mid_rst_rd", data_rd, 32'h0);
        chk("mid_rst_irq", {31'h0, irq_o}, 32'h0);
        tick(2);
        rstn = 1'b1;
        rd(3, 32'h00, "post_rst_ien");
        rd(0, 32'h00, "post_rst_data");
        rd(1, 32'h00, "post_rst_rise");
        rd(2, 32'h00, "post_rst_fall");
        tick(1);
        rd(1, 32'h00, "post_rst_rise_edge6_pre");
        rd(1, 32'hFF, "post_rst_rise_ff");
        rd(0, 32'hFF, "post_rst_data_ff");
        chk("post_rst_irq", {31'h0, irq_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
